frame_bounds_scheduler: RTL and testbench

- Frame-synchronous controller that sequences the sprite-box datapath of the VGA pipeline.
- On each end-of-frame pulse it snapshots the game-side object centres and game_state. It then computes the clamped bounding boxes one object per cycle through a single shared add/sub/clamp unit, and commits all boxes atomically to the pixel comparators.
- Sits between the game core (accel/target coordinates, game_state) and the per-pixel box-compare/colour-mux logic, all on the 25 MHz pixel clock.

---
 rtl/vga_pkg.sv | 16 +
 rtl/box_bound_calc.sv | 24 ++
 rtl/frame_bounds_scheduler.sv | 160 ++++++++++++++++
 tb/tb_frame_bounds_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared widths, screen limits, game-state codes and FSM encoding for the VGA sprite-box path.
package vga_pkg;

  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int MAX_X = 639;
  localparam int MAX_Y = 479;

  localparam logic [31:0] GAME_STATE_START = 32'd0;
  localparam logic [31:0] SMALL_STATE      = 32'd3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;

endpackage

// File: rtl/box_bound_calc.sv
// One-axis box bound: saturate the centre to LIMIT, then derive the low/high
// bounds as centre -/+ half, floored at 0 and capped at LIMIT.
module box_bound_calc #(
  parameter int W     = 10,
  parameter int LIMIT = 639
) (
  input  logic [W-1:0] center,
  input  logic [W-1:0] half,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] c_sat;
  logic [W:0]   sum;

  assign c_sat = (center > LIM) ? LIM : center;
  assign lo    = (c_sat > half) ? (c_sat - half) : '0;
  // One extra bit so centre + half can never wrap before the cap.
  assign sum   = {1'b0, c_sat} + {1'b0, half};
  assign hi    = (sum > {1'b0, LIM}) ? LIM : sum[W-1:0];

endmodule

// File: rtl/frame_bounds_scheduler.sv
// Per-frame sprite-box scheduler: snapshots game inputs on end-of-frame, computes
// one object's box per cycle through a shared calc unit, then commits all boxes at once.
//
// state      | meaning
// IDLE       | waiting for a screen_end rise
// COMPUTE    | one object per cycle into shadow registers
// COMMIT     | shadow -> outputs, frame_count += 1
module frame_bounds_scheduler
  import vga_pkg::*;
#(
  parameter int          NUM_OBJ           = 2,
  parameter int          PLAYER_HALF       = 20,
  parameter int          PLAYER_HALF_SMALL = 10,
  parameter int          TARGET_HALF       = 30,
  parameter int          TARGET_HALF_SMALL = 20,
  parameter logic [31:0] SMALL_STATE       = 32'd3,
  parameter int          MAX_X             = 639,
  parameter int          MAX_Y             = 479
) (
  input  logic                     clk_25mHz,
  input  logic                     reset,
  input  logic                     screen_end,
  input  logic [31:0]              game_state,
  input  logic [X_W*NUM_OBJ-1:0]   center_x,
  input  logic [Y_W*NUM_OBJ-1:0]   center_y,
  output logic [X_W*NUM_OBJ-1:0]   left_x,
  output logic [X_W*NUM_OBJ-1:0]   right_x,
  output logic [Y_W*NUM_OBJ-1:0]   top_y,
  output logic [Y_W*NUM_OBJ-1:0]   bottom_y,
  output logic [NUM_OBJ-1:0]       obj_en,
  output logic                     busy,
  output logic [15:0]              frame_count,
  output logic                     overrun
);

  localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

  logic [1:0]               state;
  logic                     screen_end_q;
  logic                     rise;
  logic [IDX_W-1:0]         idx;
  logic [X_W*NUM_OBJ-1:0]   snap_cx;
  logic [Y_W*NUM_OBJ-1:0]   snap_cy;
  logic [31:0]              snap_gs;
  logic [X_W*NUM_OBJ-1:0]   sh_left;
  logic [X_W*NUM_OBJ-1:0]   sh_right;
  logic [Y_W*NUM_OBJ-1:0]   sh_top;
  logic [Y_W*NUM_OBJ-1:0]   sh_bottom;
  logic [NUM_OBJ-1:0]       sh_en;

  logic [X_W-1:0] cur_cx, half_x, calc_left, calc_right;
  logic [Y_W-1:0] cur_cy, half_y, calc_top, calc_bottom;
  logic           is_small, is_start;

  assign rise     = screen_end & ~screen_end_q;
  assign busy     = (state != ST_IDLE);
  assign is_small = (snap_gs == SMALL_STATE);
  assign is_start = (snap_gs == GAME_STATE_START);

  always_comb begin
    cur_cx = '0;
    cur_cy = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_cx = snap_cx[i*X_W +: X_W];
        cur_cy = snap_cy[i*Y_W +: Y_W];
      end
    end
  end

  // Object 0 is the player; every other index uses the target sizes.
  always_comb begin
    half_x = '0;
    half_y = '0;
    if (idx == '0) begin
      half_x = is_small ? X_W'(PLAYER_HALF_SMALL) : X_W'(PLAYER_HALF);
      half_y = is_small ? Y_W'(PLAYER_HALF_SMALL) : Y_W'(PLAYER_HALF);
    end else begin
      half_x = is_small ? X_W'(TARGET_HALF_SMALL) : X_W'(TARGET_HALF);
      half_y = is_small ? Y_W'(TARGET_HALF_SMALL) : Y_W'(TARGET_HALF);
    end
  end

  box_bound_calc #(.W(X_W), .LIMIT(MAX_X)) u_calc_x (
    .center (cur_cx),
    .half   (half_x),
    .lo     (calc_left),
    .hi     (calc_right)
  );

  box_bound_calc #(.W(Y_W), .LIMIT(MAX_Y)) u_calc_y (
    .center (cur_cy),
    .half   (half_y),
    .lo     (calc_top),
    .hi     (calc_bottom)
  );

  always_ff @(posedge clk_25mHz) begin
    if (reset) begin
      state        <= ST_IDLE;
      screen_end_q <= 1'b0;
      idx          <= '0;
      snap_cx      <= '0;
      snap_cy      <= '0;
      snap_gs      <= '0;
      sh_left      <= '0;
      sh_right     <= '0;
      sh_top       <= '0;
      sh_bottom    <= '0;
      sh_en        <= '0;
      left_x       <= '0;
      right_x      <= '0;
      top_y        <= '0;
      bottom_y     <= '0;
      obj_en       <= '0;
      frame_count  <= '0;
      overrun      <= 1'b0;
    end else begin
      screen_end_q <= screen_end;
      if (rise && (state != ST_IDLE)) overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (rise) begin
            snap_cx <= center_x;
            snap_cy <= center_y;
            snap_gs <= game_state;
            idx     <= '0;
            state   <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          for (int i = 0; i < NUM_OBJ; i++) begin
            if (idx == IDX_W'(i)) begin
              sh_left[i*X_W +: X_W]   <= is_start ? '0 : calc_left;
              sh_right[i*X_W +: X_W]  <= is_start ? '0 : calc_right;
              sh_top[i*Y_W +: Y_W]    <= is_start ? '0 : calc_top;
              sh_bottom[i*Y_W +: Y_W] <= is_start ? '0 : calc_bottom;
              sh_en[i]                <= ~is_start;
            end
          end
          if (idx == LAST_IDX) state <= ST_COMMIT;
          else                 idx   <= idx + IDX_W'(1);
        end
        ST_COMMIT: begin
          left_x      <= sh_left;
          right_x     <= sh_right;
          top_y       <= sh_top;
          bottom_y    <= sh_bottom;
          obj_en      <= sh_en;
          frame_count <= frame_count + 16'd1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_bounds_scheduler.sv
// Directed bench for frame_bounds_scheduler: expected boxes are queued when a frame
// is launched and checked against the outputs once the commit has happened.
module tb_frame_bounds_scheduler;

  logic        clk_25mHz = 1'b0;
  logic        reset;
  logic        screen_end;
  logic [31:0] game_state;
  logic [19:0] center_x;
  logic [17:0] center_y;
  logic [19:0] left_x, right_x;
  logic [17:0] top_y, bottom_y;
  logic [1:0]  obj_en;
  logic        busy;
  logic [15:0] frame_count;
  logic        overrun;

  always #20 clk_25mHz = ~clk_25mHz;

  frame_bounds_scheduler dut (
    .clk_25mHz   (clk_25mHz),
    .reset       (reset),
    .screen_end  (screen_end),
    .game_state  (game_state),
    .center_x    (center_x),
    .center_y    (center_y),
    .left_x      (left_x),
    .right_x     (right_x),
    .top_y       (top_y),
    .bottom_y    (bottom_y),
    .obj_en      (obj_en),
    .busy        (busy),
    .frame_count (frame_count),
    .overrun     (overrun)
  );

  typedef struct packed {
    logic [19:0] l;
    logic [19:0] r;
    logic [17:0] t;
    logic [17:0] b;
    logic [1:0]  en;
    logic [15:0] fc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_fc;

  task automatic step();
    @(posedge clk_25mHz);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] gs, input logic [19:0] cx,
                                 input logic [17:0] cy, input logic [15:0] fc);
    exp_t e;
    int   x, y, h;
    e    = '0;
    e.fc = fc;
    if (gs == 32'd0) return e;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) h = (gs == 32'd3) ? 10 : 20;
      else        h = (gs == 32'd3) ? 20 : 30;
      x = int'(cx[i*10 +: 10]);
      y = int'(cy[i*9 +: 9]);
      if (x > 639) x = 639;
      if (y > 479) y = 479;
      e.l[i*10 +: 10] = 10'((x > h) ? x - h : 0);
      e.r[i*10 +: 10] = 10'((x + h > 639) ? 639 : x + h);
      e.t[i*9 +: 9]   = 9'((y > h) ? y - h : 0);
      e.b[i*9 +: 9]   = 9'((y + h > 479) ? 479 : y + h);
      e.en[i]         = 1'b1;
    end
    return e;
  endfunction

  task automatic start_frame(input logic [31:0] gs, input logic [19:0] cx,
                             input logic [17:0] cy, input bit push);
    game_state = gs;
    center_x   = cx;
    center_y   = cy;
    screen_end = 1'b1;
    if (push) begin
      exp_fc = exp_fc + 16'd1;
      sb.push_back(model(gs, cx, cy, exp_fc));
    end
    step();
    screen_end = 1'b0;
  endtask

  task automatic finish_frame(input bit chk_len);
    int   n     = 0;
    int   guard = 0;
    exp_t e;
    while (busy === 1'b1 && guard < 20) begin
      n++;
      step();
      guard++;
    end
    check("idle_reached", 32'(busy), 32'd0);
    if (chk_len) check("busy_len", 32'(n), 32'd3);
    check("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("left_x",      32'(left_x),      32'(e.l));
      check("right_x",     32'(right_x),     32'(e.r));
      check("top_y",       32'(top_y),       32'(e.t));
      check("bottom_y",    32'(bottom_y),    32'(e.b));
      check("obj_en",      32'(obj_en),      32'(e.en));
      check("frame_count", 32'(frame_count), 32'(e.fc));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_left"},   32'(left_x),      32'd0);
    check({tag, "_right"},  32'(right_x),     32'd0);
    check({tag, "_top"},    32'(top_y),       32'd0);
    check({tag, "_bottom"}, 32'(bottom_y),    32'd0);
    check({tag, "_en"},     32'(obj_en),      32'd0);
    check({tag, "_busy"},   32'(busy),        32'd0);
    check({tag, "_fc"},     32'(frame_count), 32'd0);
    check({tag, "_ovr"},    32'(overrun),     32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    screen_end = 1'b0;
    game_state = 32'd0;
    center_x   = '0;
    center_y   = '0;
    exp_fc     = 16'd0;
    step(); step(); step();
    check_all_zero("reset");
    reset = 1'b0;
    step();

    // Normal mode, player (320,240), target (100,100).
    start_frame(32'd1, {10'd100, 10'd320}, {9'd100, 9'd240}, 1'b1);
    finish_frame(1'b1);
    check("f1_left_const",   32'(left_x),   32'({10'd70, 10'd300}));
    check("f1_bottom_const", 32'(bottom_y), 32'({9'd130, 9'd260}));
    check("f1_overrun",      32'(overrun),  32'd0);

    // Small mode with edge clamping; launched the cycle after the previous commit.
    start_frame(32'd3, {10'd630, 10'd5}, {9'd4, 9'd475}, 1'b1);
    finish_frame(1'b1);
    check("f2_right_const", 32'(right_x), 32'({10'd639, 10'd15}));
    check("f2_top_const",   32'(top_y),   32'({9'd0, 9'd465}));

    // Start screen: everything blanked, frame still counted.
    start_frame(32'd0, {10'd300, 10'd200}, {9'd300, 9'd200}, 1'b1);
    finish_frame(1'b1);

    // Input change after capture must not leak into this frame.
    start_frame(32'd1, {10'd100, 10'd320}, {9'd100, 9'd240}, 1'b1);
    center_x = {10'd100, 10'd400};
    finish_frame(1'b1);
    check("snap_left_const", 32'(left_x[9:0]), 32'd300);
    start_frame(32'd1, {10'd100, 10'd400}, {9'd100, 9'd240}, 1'b1);
    finish_frame(1'b1);
    check("next_left_const", 32'(left_x[9:0]), 32'd380);

    // Second rise during COMPUTE, with an off-screen target centre.
    start_frame(32'd1, {10'd700, 10'd320}, {9'd100, 9'd240}, 1'b1);
    step();
    screen_end = 1'b1;
    step();
    screen_end = 1'b0;
    finish_frame(1'b0);
    check("ovr_set",         32'(overrun),        32'd1);
    check("sat_right_const", 32'(right_x[19:10]), 32'd639);
    step(); step(); step();
    check("ovr_no_extra_commit", 32'(frame_count), 32'(exp_fc));
    check("ovr_sticky",          32'(overrun),     32'd1);

    // Reset in the middle of COMPUTE discards the sequence.
    start_frame(32'd1, {10'd50, 10'd60}, {9'd70, 9'd80}, 1'b0);
    step();
    reset = 1'b1;
    step();
    check_all_zero("abort");
    reset  = 1'b0;
    exp_fc = 16'd0;
    step();
    start_frame(32'd1, {10'd200, 10'd150}, {9'd300, 9'd100}, 1'b1);
    finish_frame(1'b1);
    check("post_reset_fc", 32'(frame_count), 32'd1);
    check("sb_drained",    32'(sb.size()),    32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
